// File: rtl/lif_pkg.sv
// Shared types and range helpers for the LIF neuron datapath.
package lif_pkg;

    typedef enum logic {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } lif_state_t;

    // Largest positive two's-complement value of a given width.
    function automatic int MAX_VALUE(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // Most negative two's-complement value of a given width.
    function automatic int MIN_VALUE(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/lif_membrane_refractory_counter.sv
// Down-counter timing the refractory period; terminal count is flagged by last.
module refractory_counter
    import lif_pkg::*;
#(
    parameter int REFRACT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [REFRACT_WIDTH-1:0] value,
    input  logic                     dec,
    output logic                     active,
    output logic                     last
);

    logic [REFRACT_WIDTH-1:0] rcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
        end else if (load) begin
            rcnt <= value;
        end else if (dec && (rcnt != '0)) begin
            rcnt <= rcnt - 1'b1;
        end
    end

    assign active = (rcnt != '0);
    assign last   = (rcnt == REFRACT_WIDTH'(1));

endmodule

// File: rtl/lif_membrane.sv
// LIF membrane stage: registers the normalized potential, fires on threshold,
// resets by subtraction and holds off integration for a refractory period.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   INTEGRATE  | u_in is accepted each enabled cycle; fires when u_in >= threshold
//   REFRACTORY | u_in ignored; membrane leaks; counter runs down to INTEGRATE
module lif_membrane
    import lif_pkg::*;
#(
    parameter int WIDTH         = 6,
    parameter int REFRACT_WIDTH = 4,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic signed [WIDTH-1:0]  u_in,
    input  logic [WIDTH-2:0]         threshold,
    input  logic [2:0]               leak_shift,
    input  logic [REFRACT_WIDTH-1:0] refract_cycles,
    input  logic                     count_clear,
    output logic signed [WIDTH-1:0]  u_fb,
    output logic                     spike,
    output logic                     refractory,
    output logic [COUNT_WIDTH-1:0]   spike_count
);

    lif_state_t state, state_next;

    logic signed [WIDTH-1:0] u_reg, u_next;
    logic signed [WIDTH-1:0] thr_ext;
    logic signed [WIDTH-1:0] u_shifted;
    logic signed [WIDTH-1:0] u_diff;
    logic                    at_threshold;
    logic                    spike_next;
    logic                    fire;
    logic                    rc_load;
    logic                    rc_dec;
    logic                    rc_active;
    logic                    rc_last;

    // Leak never overflows: subtracting a shifted copy shrinks the magnitude.
    assign u_shifted = u_reg >>> leak_shift;
    assign u_fb      = (leak_shift == 3'd0) ? u_reg : (u_reg - u_shifted);

    assign thr_ext      = $signed({1'b0, threshold});
    assign at_threshold = (u_in >= thr_ext);
    assign u_diff       = u_in - thr_ext;

    refractory_counter #(
        .REFRACT_WIDTH(REFRACT_WIDTH)
    ) u_refractory_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (rc_load),
        .value  (refract_cycles),
        .dec    (rc_dec),
        .active (rc_active),
        .last   (rc_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INTEGRATE;
            u_reg <= '0;
            spike <= 1'b0;
        end else begin
            state <= state_next;
            u_reg <= u_next;
            spike <= spike_next;
        end
    end

    always_comb begin
        state_next = state;
        u_next     = u_reg;
        spike_next = 1'b0;
        fire       = 1'b0;
        rc_load    = 1'b0;
        rc_dec     = 1'b0;
        if (enable) begin
            case (state)
                INTEGRATE: begin
                    if (at_threshold) begin
                        fire       = 1'b1;
                        spike_next = 1'b1;
                        u_next     = u_diff;
                        if (refract_cycles != '0) begin
                            rc_load    = 1'b1;
                            state_next = REFRACTORY;
                        end
                    end else begin
                        u_next = u_in;
                    end
                end
                REFRACTORY: begin
                    u_next = u_fb;
                    rc_dec = 1'b1;
                    // An idle counter here is unreachable; recover to INTEGRATE anyway.
                    if (rc_last || !rc_active) begin
                        state_next = INTEGRATE;
                    end
                end
                default: state_next = INTEGRATE;
            endcase
        end
    end

    assign refractory = (state == REFRACTORY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_count <= '0;
        end else if (count_clear) begin
            spike_count <= '0;
        end else if (fire && (spike_count != '1)) begin
            spike_count <= spike_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_lif_membrane.sv
// Directed-vector bench for lif_membrane with hand-computed expectations.
module tb_lif_membrane;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic signed [5:0] u_in;
    logic [4:0]        threshold;
    logic [2:0]        leak_shift;
    logic [3:0]        refract_cycles;
    logic              count_clear;
    logic signed [5:0] u_fb;
    logic              spike;
    logic              refractory;
    logic [7:0]        spike_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lif_membrane #(
        .WIDTH(6),
        .REFRACT_WIDTH(4),
        .COUNT_WIDTH(8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .u_in          (u_in),
        .threshold     (threshold),
        .leak_shift    (leak_shift),
        .refract_cycles(refract_cycles),
        .count_clear   (count_clear),
        .u_fb          (u_fb),
        .spike         (spike),
        .refractory    (refractory),
        .spike_count   (spike_count)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int fb, input int sp, input int rf, input int cnt);
        check_val({tag, ".u_fb"},        int'(u_fb),        fb);
        check_val({tag, ".spike"},       int'(spike),       sp);
        check_val({tag, ".refractory"},  int'(refractory),  rf);
        check_val({tag, ".spike_count"}, int'(spike_count), cnt);
    endtask

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b0;
        u_in           = '0;
        threshold      = 5'd20;
        leak_shift     = 3'd0;
        refract_cycles = 4'd0;
        count_clear    = 1'b0;
        #12;
        expect_out("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Sub-threshold integration.
        u_in = 6'sd10; step(); expect_out("sub10", 10, 0, 0, 0);
        u_in = 6'sd15; step(); expect_out("sub15", 15, 0, 0, 0);
        u_in = 6'sd19; step(); expect_out("sub19", 19, 0, 0, 0);

        // Fire and subtract, then spike drops after one cycle.
        u_in = 6'sd27; step(); expect_out("fire27", 7, 1, 0, 1);
        u_in = 6'sd5;  step(); expect_out("after27", 5, 0, 0, 1);

        threshold = 5'd31; u_in = 6'sd31; step(); expect_out("fire31", 0, 1, 0, 2);

        threshold = 5'd20; u_in = -6'sd32; step(); expect_out("neg32", -32, 0, 0, 2);
        leak_shift = 3'd1; step(); expect_out("leak1", -16, 0, 0, 2);
        leak_shift = 3'd0;

        // Refractory period of 3; changing refract_cycles mid-period must not matter.
        refract_cycles = 4'd3; u_in = 6'sd27; step(); expect_out("rfire", 7, 1, 1, 3);
        refract_cycles = 4'd15; u_in = 6'sd31;
        step(); expect_out("rc1", 7, 0, 1, 3);
        step(); expect_out("rc2", 7, 0, 1, 3);
        step(); expect_out("rc3", 7, 0, 0, 3);
        step(); expect_out("rc4fire", 11, 1, 1, 4);
        leak_shift = 3'd2;
        step(); expect_out("rleak", 7, 0, 1, 4);

        enable = 1'b0;
        step(); expect_out("hold1", 7, 0, 1, 4);
        step(); expect_out("hold2", 7, 0, 1, 4);

        // Reset mid-cycle during refractory.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        expect_out("midreset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n          = 1'b1;
        enable         = 1'b1;
        leak_shift     = 3'd0;
        refract_cycles = 4'd0;
        u_in           = 6'sd25;
        step(); expect_out("postreset", 5, 1, 0, 1);

        // Enable gaps inside a refractory period of 2.
        refract_cycles = 4'd2;
        step(); expect_out("gfire", 5, 1, 1, 2);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); expect_out("gap", 5, 0, 1, 2);
        end
        enable = 1'b1; u_in = 6'sd31;
        step(); expect_out("gen1", 5, 0, 1, 2);
        step(); expect_out("gen2", 5, 0, 0, 2);
        step(); expect_out("gfire2", 11, 1, 1, 3);

        // Saturation with every-cycle firing.
        refract_cycles = 4'd0; threshold = 5'd0; u_in = 6'sd5;
        for (int i = 0; i < 300; i++) step();
        expect_out("sat", 5, 1, 0, 255);

        count_clear = 1'b1; step(); expect_out("clr", 5, 1, 0, 0);
        count_clear = 1'b0; step(); expect_out("postclr", 5, 1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
